mio_data_responder: RTL

//  Memory/IO responder on the CPU data-side MIO interface: serves loads and

---
 rtl/mio_data_responder.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/mio_data_responder.sv
// mio_data_responder: data-side MIO responder for the pipeline CPU.
// Serves loads/stores from a local word RAM after WAIT_CYCLES wait states,
// returning a one-cycle MIO_ready acknowledge with registered data/error.
// Optional feature macro: MIO_BYTE_LANE_EN (Fun3 byte/half lanes, alignment
// checks). Without it every access is a full word and Addr_in[1:0] is ignored.
module mio_data_responder #(
  parameter int unsigned ADDR_W      = 10,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        CPU_MIO,
  input  logic        MemRW,
  input  logic [31:0] Addr_in,
  input  logic [31:0] Data_out,
  input  logic [2:0]  Fun3,
  output logic [31:0] Data_in,
  output logic        MIO_ready,
  output logic        MIO_err
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_ACK} state_t;

  localparam bit         NO_WAIT  = (WAIT_CYCLES == 0);
  localparam logic [3:0] CNT_INIT = NO_WAIT ? 4'd0 : 4'(WAIT_CYCLES - 1);

  state_t              r_state;
  logic [3:0]          r_cnt;
  logic                r_we;
  logic                r_bad;
  logic [ADDR_W-1:0]   r_idx;
  logic [31:0]         r_wdata;
  logic [31:0]         r_data_in;
  logic                r_ready;
  logic                r_err;
  logic [31:0]         r_mem [0:(1<<ADDR_W)-1];
`ifdef MIO_BYTE_LANE_EN
  logic [2:0]          r_fun3;
  logic [1:0]          r_lane;
  logic [2:0]          w_sel_fun3;
  logic [1:0]          w_sel_lane;
  logic [31:0]         w_shift;
`endif

  logic [31:0]         w_off;
  logic                w_req_bad;
  logic [ADDR_W-1:0]   w_req_idx;
  logic                w_sel_we;
  logic                w_sel_bad;
  logic [ADDR_W-1:0]   w_sel_idx;
  logic [31:0]         w_sel_wdata;
  logic                w_enter_ack;
  logic                w_commit;
  logic [31:0]         w_rword;
  logic [31:0]         w_load;
  logic [3:0]          w_be;
  logic [31:0]         w_wdata;
  logic                w_unused;

  assign w_off     = Addr_in - BASE_ADDR;
  assign w_req_idx = w_off[ADDR_W+1:2];
`ifdef MIO_BYTE_LANE_EN
  assign w_unused  = ^w_off[1:0];
`else
  assign w_unused  = ^{w_off[1:0], Fun3};
`endif

  // With zero wait states the access completes straight from IDLE, so the
  // commit path must see the live request rather than the latched copy.
  assign w_sel_we    = (r_state == S_IDLE) ? MemRW     : r_we;
  assign w_sel_bad   = (r_state == S_IDLE) ? w_req_bad : r_bad;
  assign w_sel_idx   = (r_state == S_IDLE) ? w_req_idx : r_idx;
  assign w_sel_wdata = (r_state == S_IDLE) ? Data_out  : r_wdata;
`ifdef MIO_BYTE_LANE_EN
  assign w_sel_fun3  = (r_state == S_IDLE) ? Fun3         : r_fun3;
  assign w_sel_lane  = (r_state == S_IDLE) ? Addr_in[1:0] : r_lane;
`endif

  assign w_enter_ack = (r_state == S_IDLE && CPU_MIO && NO_WAIT) ||
                       (r_state == S_BUSY && r_cnt == '0);
  assign w_commit    = w_enter_ack && w_sel_we && !w_sel_bad && rst_n;

  // Request error: outside the window (wrapping offset) or misaligned/illegal size.
  always_comb begin
    w_req_bad = |(w_off >> (ADDR_W + 2));
`ifdef MIO_BYTE_LANE_EN
    if (MemRW) begin
      case (Fun3)
        3'b000:  ;
        3'b001:  if (Addr_in[0])     w_req_bad = 1'b1;
        3'b010:  if (|Addr_in[1:0])  w_req_bad = 1'b1;
        default: w_req_bad = 1'b1;
      endcase
    end else begin
      case (Fun3)
        3'b000, 3'b100: ;
        3'b001, 3'b101: if (Addr_in[0])    w_req_bad = 1'b1;
        3'b010:         if (|Addr_in[1:0]) w_req_bad = 1'b1;
        default:        w_req_bad = 1'b1;
      endcase
    end
`endif
  end

  // Load formatting: lane select and sign/zero extension of the addressed word.
  always_comb begin
    w_rword = r_mem[w_sel_idx];
    w_load  = w_rword;
`ifdef MIO_BYTE_LANE_EN
    w_shift = w_rword >> {w_sel_lane, 3'b000};
    case (w_sel_fun3)
      3'b000:  w_load = {{24{w_shift[7]}},  w_shift[7:0]};
      3'b001:  w_load = {{16{w_shift[15]}}, w_shift[15:0]};
      3'b100:  w_load = {24'd0, w_shift[7:0]};
      3'b101:  w_load = {16'd0, w_shift[15:0]};
      default: w_load = w_rword;
    endcase
`endif
  end

  // Store formatting: replicate narrow data onto all lanes, enable only target bytes.
  always_comb begin
    w_be    = '1;
    w_wdata = w_sel_wdata;
`ifdef MIO_BYTE_LANE_EN
    case (w_sel_fun3)
      3'b000: begin
        w_be    = 4'b0001 << w_sel_lane;
        w_wdata = {4{w_sel_wdata[7:0]}};
      end
      3'b001: begin
        w_be    = 4'b0011 << w_sel_lane;
        w_wdata = {2{w_sel_wdata[15:0]}};
      end
      default: ;
    endcase
`endif
  end

  // Data RAM write port (contents intentionally not reset).
  always_ff @(posedge clk) begin
    if (w_commit) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (w_be[b]) r_mem[w_sel_idx][8*b +: 8] <= w_wdata[8*b +: 8];
      end
    end
  end

  // Access FSM with request latches and registered acknowledge outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_we      <= 1'b0;
      r_bad     <= 1'b0;
      r_idx     <= '0;
      r_wdata   <= '0;
      r_data_in <= '0;
      r_ready   <= 1'b0;
      r_err     <= 1'b0;
`ifdef MIO_BYTE_LANE_EN
      r_fun3    <= '0;
      r_lane    <= '0;
`endif
    end else begin
      r_ready <= w_enter_ack;
      r_err   <= w_enter_ack && w_sel_bad;
      if (w_enter_ack) begin
        if (w_sel_bad)     r_data_in <= '0;
        else if (!w_sel_we) r_data_in <= w_load;
      end
      case (r_state)
        S_IDLE: begin
          if (CPU_MIO) begin
            r_we    <= MemRW;
            r_bad   <= w_req_bad;
            r_idx   <= w_req_idx;
            r_wdata <= Data_out;
`ifdef MIO_BYTE_LANE_EN
            r_fun3  <= Fun3;
            r_lane  <= Addr_in[1:0];
`endif
            r_cnt   <= CNT_INIT;
            r_state <= NO_WAIT ? S_ACK : S_BUSY;
          end
        end
        S_BUSY: begin
          if (r_cnt == '0) r_state <= S_ACK;
          else             r_cnt   <= r_cnt - 4'd1;
        end
        S_ACK:   r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign Data_in   = r_data_in;
  assign MIO_ready = r_ready;
  assign MIO_err   = r_err;

endmodule
